// File: rtl/pipe_stage.sv
// Pipeline stage register with valid/ready handshake, flush and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with registered in_ready_o.
module pipe_stage #(
  parameter int WIDTH       = 64,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WIDTH-1:0]       in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WIDTH-1:0]       out_data_o,
  input  logic                   flush_i,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  input  logic                   stall_cnt_clr_i
);

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  logic             in_hs;
  logic             out_hs;
  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic [STALL_CNT_W-1:0] stall_cnt;

  assign in_hs       = in_valid_i && in_ready_o;
  assign out_hs      = main_valid && out_ready_i;
  assign out_valid_o = main_valid;
  assign out_data_o  = main_data;
  assign stall_cnt_o = stall_cnt;

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             ready;

  assign in_ready_o = ready;

  // Skid FSM: ready is kept equal to !skid_valid so the upstream sees a flop output.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_EMPTY;
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      ready      <= 1'b1;
    end else if (flush_i) begin
      state      <= ST_EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready      <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_hs) begin
            main_data  <= in_data_i;
            main_valid <= 1'b1;
            state      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_hs && !out_hs) begin
            skid_data  <= in_data_i;
            skid_valid <= 1'b1;
            ready      <= 1'b0;
            state      <= ST_TWO;
          end else if (in_hs && out_hs) begin
            main_data <= in_data_i;
          end else if (out_hs) begin
            main_valid <= 1'b0;
            state      <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_hs) begin
            main_data  <= skid_data;
            skid_valid <= 1'b0;
            ready      <= 1'b1;
            state      <= ST_ONE;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
          ready      <= 1'b1;
        end
      endcase
    end
  end

`else

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t state;

  // Ready passes straight through from downstream when the stage is occupied.
  assign in_ready_o = !main_valid || out_ready_i;

  // Single-register FSM.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_EMPTY;
      main_valid <= 1'b0;
      main_data  <= '0;
    end else if (flush_i) begin
      state      <= ST_EMPTY;
      main_valid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_hs) begin
            main_data  <= in_data_i;
            main_valid <= 1'b1;
            state      <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_hs) begin
            main_data <= in_data_i;
          end else if (out_hs) begin
            main_valid <= 1'b0;
            state      <= ST_EMPTY;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          main_valid <= 1'b0;
        end
      endcase
    end
  end

`endif

  // Stall counter: clear beats increment, saturates at all-ones, ignores flush.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt <= '0;
    end else if (stall_cnt_clr_i) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready_i && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Directed self-checking bench for pipe_stage; skid checks follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       flush;
  logic [3:0] stall_cnt;
  logic       stall_clr;

  int n_cmp;
  int n_err;

  pipe_stage #(.WIDTH(8), .STALL_CNT_W(4)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .flush_i        (flush),
    .stall_cnt_o    (stall_cnt),
    .stall_cnt_clr_i(stall_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge; outputs are then checked 1 time unit later.
  task automatic drive(input logic v, input logic [7:0] d, input logic ordy,
                       input logic fl, input logic clr);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    stall_clr = clr;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h want=00", out_data); end
    n_cmp++; if (stall_cnt !== 4'h0) begin n_err++; $display("FAIL reset_stall got=%h want=0", stall_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream;
    logic [7:0] exp_d;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready got=%b want=1", in_ready); end
    for (int i = 2; i <= 4; i++) begin
      exp_d = 8'(i - 1);
      drive((i <= 3) ? 1'b1 : 1'b0, 8'(i), 1'b1, 1'b0, 1'b0);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_d) begin
        n_err++; $display("FAIL stream_data got=%b/%h want=1/%h", out_valid, out_data, exp_d);
      end
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got=%b want=0", out_valid); end
    n_cmp++; if (stall_cnt !== 4'h0) begin n_err++; $display("FAIL stream_stall got=%h want=0", stall_cnt); end
  endtask

`ifdef PIPE_STAGE_SKID_EN
  task automatic test_backpressure;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b1 || out_data !== 8'h0A) begin
      n_err++; $display("FAIL bp_one got=%b/%h want=1/0a", in_ready, out_data);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_drop got=%b want=0", in_ready); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_data !== 8'h0A || stall_cnt !== 4'h3) begin
      n_err++; $display("FAIL bp_release got=%h/%h want=0a/3", out_data, stall_cnt);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h0B || in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_second got=%b/%h/%b want=1/0b/1", out_valid, out_data, in_ready);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0 || stall_cnt !== 4'h3) begin
      n_err++; $display("FAIL bp_empty got=%b/%h want=0/3", out_valid, stall_cnt);
    end
  endtask

  task automatic test_flush;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h06, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h07, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_pre got=%b/%b want=1/0", out_valid, in_ready);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_post got=%b/%b want=0/1", out_valid, in_ready);
    end
    n_cmp++; if (stall_cnt !== 4'h2) begin n_err++; $display("FAIL flush_stall got=%h want=2", stall_cnt); end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_gone got=%b want=0", out_valid); end
  endtask
`else
  task automatic test_backpressure;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_empty_ready got=%b want=1", in_ready); end
    drive(1'b1, 8'h0C, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b0 || out_data !== 8'h0B) begin
      n_err++; $display("FAIL bp_full got=%b/%h want=0/0b", in_ready, out_data);
    end
    drive(1'b1, 8'h0C, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (stall_cnt !== 4'h1) begin n_err++; $display("FAIL bp_stall got=%h want=1", stall_cnt); end
    drive(1'b1, 8'h0C, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b1 || out_data !== 8'h0B) begin
      n_err++; $display("FAIL bp_release got=%b/%h want=1/0b", in_ready, out_data);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h0C || stall_cnt !== 4'h2) begin
      n_err++; $display("FAIL bp_second got=%b/%h/%h want=1/0c/2", out_valid, out_data, stall_cnt);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_flush;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h06, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre got=%b want=1", out_valid); end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_post got=%b want=0", out_valid); end
    n_cmp++; if (stall_cnt !== 4'h1) begin n_err++; $display("FAIL flush_stall got=%h want=1", stall_cnt); end
  endtask
`endif

  task automatic test_flush_discard;
    drive(1'b1, 8'h09, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fd_ready got=%b want=1", in_ready); end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fd_discard got=%b want=0", out_valid); end
  endtask

  task automatic test_counter;
    logic [3:0] exp_c;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      exp_c = (i > 15) ? 4'hF : 4'(i);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (stall_cnt !== exp_c) begin
        n_err++; $display("FAIL cnt_sat i=%0d got=%h want=%h", i, stall_cnt, exp_c);
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (stall_cnt !== 4'h0) begin n_err++; $display("FAIL cnt_clr got=%h want=0", stall_cnt); end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (stall_cnt !== 4'h1 || out_data !== 8'h33) begin
      n_err++; $display("FAIL cnt_resume got=%h/%h want=1/33", stall_cnt, out_data);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
      n_err++; $display("FAIL rm_pre got=%b/%h want=1/5a", out_valid, out_data);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      n_err++; $display("FAIL rm_async got=%b/%h want=0/00", out_valid, out_data);
    end
    n_cmp++; if (stall_cnt !== 4'h0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL rm_state got=%h/%b want=0/1", stall_cnt, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    flush     = 1'b0;
    stall_clr = 1'b0;
    test_reset;
    test_stream;
    test_backpressure;
    test_flush;
    test_flush_discard;
    test_counter;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline stage register with a valid/ready handshake, flush and a stall counter. It generalises the core's fixed inter-stage registers (fetch→decode, decode→execute) so every stage boundary can apply backpressure and be squashed on redirect. One instance sits between each pair of adjacent pipeline stages, and it carries an opaque payload bundle such as `{pc, instr}`.

## Interface
Parameters:
- `WIDTH`, 64: payload width in bits; the minimum is 1.
- `STALL_CNT_W`, 16: width of the stall counter.

Ports:
- `clk_i`  in  1  clock; all logic is rising-edge.
- `rst_n_i`  in  1  reset, asynchronous assert, active-low.
- `in_valid_i`  in  1  upstream has a payload.
- `in_ready_o`  out  1  stage can accept this cycle.
- `in_data_i`  in  WIDTH  upstream payload.
- `out_valid_o`  out  1  stage presents a payload.
- `out_ready_i`  in  1  downstream accepts this cycle.
- `out_data_o`  out  WIDTH  payload presented downstream.
- `flush_i`  in  1  squash all held payloads; synchronous.
- `stall_cnt_o`  out  STALL_CNT_W  saturating count of stalled cycles.
- `stall_cnt_clr_i`  in  1  synchronous clear of the stall counter.

## Operation
- An input handshake happens when `in_valid_i && in_ready_o`. An output handshake happens when `out_valid_o && out_ready_i`.
- Payloads leave in the order they arrived. No payload is duplicated or dropped, except on flush.
- The main register, and the skid register when present, load only on an accepted handshake. When a register's valid bit is 0, its data is don't-care and holds its previous value.
- `out_data_o` comes straight from the main register, with no combinational path from `in_data_i`.
- Flush:
  - On the cycle after `flush_i`, all valid bits are 0.
  - An input handshake in the flush cycle is discarded.
  - `in_ready_o` is not gated by `flush_i`.
  - Flush takes priority over every other event.
- Stall counter:
  - Increments each cycle that `out_valid_o && !out_ready_i` holds.
  - Saturates at all-ones.
  - `stall_cnt_clr_i` sets it to 0 and wins over an increment in the same cycle.
  - Flush does not affect it.
- Skid mode (macro defined) uses three states:
  - EMPTY: `in_ready_o`=1, `out_valid_o`=0. An input handshake moves to ONE.
  - ONE: `in_ready_o`=1, `out_valid_o`=1.
    - Input handshake without output handshake: load skid, go to TWO.
    - Input and output handshake together: reload main, stay in ONE.
    - Output handshake only: go to EMPTY.
  - TWO: `in_ready_o`=0, `out_valid_o`=1. An output handshake moves skid into main and goes to ONE.
  - `in_ready_o` is a register output, equal to !skid_valid.
- Non-skid mode (macro undefined) uses two states:
  - EMPTY: `out_valid_o`=0. An input handshake moves to FULL.
  - FULL: `out_valid_o`=1.
    - Output handshake without input handshake: go to EMPTY.
    - Output and input handshake together: reload main, stay in FULL.
  - `in_ready_o = !valid_q || out_ready_i`, which is combinational from `out_ready_i`.

## Timing
- Reset values, applied asynchronously while `rst_n_i`=0:
  - `out_valid_o`=0, `out_data_o`=0, `stall_cnt_o`=0.
  - Skid register cleared.
  - `in_ready_o`=1 in skid mode. In non-skid mode it is 1 because valid_q=0.
- Reset is released synchronously by the surrounding reset synchroniser. The first handshake can happen on the first rising edge after deassertion.
- Latency: an input accepted at edge N is presented on `out_valid_o` and `out_data_o` right after edge N, so the downstream can take it at edge N+1. The stage adds one cycle.
- Throughput: one payload per cycle in both modes while `out_ready_i`=1.
- In skid mode, `out_ready_i` falling causes at most one extra payload to be absorbed (into skid). `in_ready_o` drops in the following cycle.
- Reset asserted mid-transfer discards every held payload immediately.

## Configuration
- `PIPE_STAGE_SKID_EN`:
  - Defined: two-entry skid buffer. `in_ready_o` is registered, which breaks the ready timing path between stages.
  - Undefined: a single register with combinational ready pass-through. This costs less area, but the ready path chains through every stage.
  - The ports and the ordering, flush and counter behaviour are identical in both modes.

## Test plan
- Streaming: `out_ready_i`=1, payloads 0x1,0x2,0x3 on consecutive cycles → the same values appear on `out_data_o` one cycle later each, with no bubble; `stall_cnt_o`=0.
- Backpressure (skid): hold `out_ready_i`=0 with 0xA,0xB offered → `in_ready_o`=0 after 0xB is accepted. On release, 0xA then 0xB come out; `stall_cnt_o` equals the number of stalled cycles.
- Backpressure (non-skid): `out_ready_i`=0 with the stage full → `in_ready_o`=0 in the same cycle. 0xC offered is held upstream and appears after release.
- Flush: stage in TWO holding 0x5,0x6, `flush_i`=1 with 0x7 offered → `out_valid_o`=0 next cycle, and 0x5, 0x6 and 0x7 never appear.
- Counter: `STALL_CNT_W`=4 with 20 stalled cycles → `stall_cnt_o` sticks at 0xF. `stall_cnt_clr_i` together with a stall → 0.
- Reset mid-stream: `rst_n_i` low while full → `out_valid_o`=0 and `out_data_o`=0 immediately, before the next clock edge.
